// File: rtl/block_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words and queues them in a small FIFO.
// Upstream errors discard the partial word; words completed while the FIFO is full are dropped.
module block_word_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  word_bus,
  input  logic        word_valid,
  input  logic        error,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        full,
  output logic [7:0]  error_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  logic [1:0]    r_lane;
  logic [23:0]   r_partial;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_data_out;
  logic          r_full;
  logic          r_overflow;
  logic [7:0]    r_err_cnt;

  logic          w_accept;
  logic          w_discard;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_word;
  logic [AW:0]   w_count_next;
  logic [AW-1:0] w_rd_ptr_next;
  logic [31:0]   w_head_next;

  assign w_accept   = word_valid & ~error;
  assign w_discard  = word_valid & error;
  assign w_push_req = w_accept & (r_lane == 2'd3);
  assign w_pop      = (r_count != '0) & data_ready;
  // A pop on the same edge frees the slot, so a full FIFO still takes the word.
  assign w_push     = w_push_req & (~r_full | w_pop);
  assign w_drop     = w_push_req & r_full & ~w_pop;
  assign w_word     = {r_partial, word_bus};

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW + 1)'(1);
    end
  end

  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // The head register mirrors the FIFO front; a word landing in an otherwise empty FIFO bypasses the array.
  always_comb begin
    w_head_next = r_data_out;
    if (w_push && (w_count_next == (AW + 1)'(1))) begin
      w_head_next = w_word;
    end else if (w_pop && (w_count_next != '0)) begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane    <= 2'd0;
      r_partial <= 24'h0;
      r_err_cnt <= 8'h0;
    end else if (w_discard) begin
      r_lane    <= 2'd0;
      r_partial <= 24'h0;
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_partial[23:16] <= word_bus;
        2'd1:    r_partial[15:8]  <= word_bus;
        2'd2:    r_partial[7:0]   <= word_bus;
        default: r_partial        <= 24'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_data_out <= 32'h0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= w_rd_ptr_next;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == C_DEPTH);
      r_data_out <= w_head_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = (r_count != '0);
  assign full        = r_full;
  assign error_count = r_err_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_block_word_packer.sv
// Directed bench for block_word_packer: stimulus pushes expected words into a queue,
// a monitor pops and compares every word the consumer accepts.
module tb_block_word_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  word_bus = 8'h0;
  logic        word_valid = 1'b0;
  logic        error = 1'b0;
  logic        data_ready = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        full;
  logic [7:0]  error_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];

  block_word_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .word_bus(word_bus),
    .word_valid(word_valid),
    .error(error),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .full(full),
    .error_count(error_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; returns 1 unit after the edge that samples them.
  task automatic send_byte(input logic [7:0] b, input logic e);
    word_valid = 1'b1;
    word_bus   = b;
    error      = e;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    error      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    data_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    data_ready = 1'b0;
    check("drain_complete", 32'(q.size()), 32'd0);
    check("empty_after_drain", 32'(data_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin : monitor
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (reset && data_valid && data_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: actual=%h required=none", data_out);
        end else begin
          exp_w = q.pop_front();
          check("popped_word", data_out, exp_w);
        end
      end
    end
  end

  initial begin
    // Bytes presented during reset must be ignored.
    word_valid = 1'b1;
    word_bus   = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_error_count", 32'(error_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    word_valid = 1'b0;
    reset = 1'b1;

    // Basic packing and one-cycle latency.
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    check("valid_before_4th", 32'(data_valid), 32'd0);
    q.push_back(32'hDEADBEEF);
    send_byte(8'hEF, 1'b0);
    check("valid_after_4th", 32'(data_valid), 32'd1);
    check("deadbeef", data_out, 32'hDEADBEEF);
    drain();

    // Error mid-word discards the partial word.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("err_count_1", 32'(error_count), 32'd1);
    error = 1'b1;
    @(posedge clk);
    #1;
    error = 1'b0;
    check("err_without_valid", 32'(error_count), 32'd1);
    q.push_back(32'h01020304);
    send_word(32'h01020304);
    check("word_after_error", data_out, 32'h01020304);
    drain();

    // Fill to DEPTH, then one extra word is dropped.
    q.push_back(32'h11223344); send_word(32'h11223344);
    q.push_back(32'h55667788); send_word(32'h55667788);
    q.push_back(32'h99AABBCC); send_word(32'h99AABBCC);
    check("not_full_at_3", 32'(full), 32'd0);
    q.push_back(32'hDDEEFF00); send_word(32'hDDEEFF00);
    check("full_at_depth", 32'(full), 32'd1);
    check("no_overflow_yet", 32'(overflow), 32'd0);
    send_word(32'h12345678);
    check("overflow_set", 32'(overflow), 32'd1);
    check("still_full", 32'(full), 32'd1);
    drain();
    check("full_cleared", 32'(full), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);
    q.push_back(32'h0F0E0D0C); send_word(32'h0F0E0D0C);
    drain();

    // Full FIFO with push and pop on the same edge.
    do_reset();
    q.push_back(32'hA1A2A3A4); send_word(32'hA1A2A3A4);
    q.push_back(32'hB1B2B3B4); send_word(32'hB1B2B3B4);
    q.push_back(32'hC1C2C3C4); send_word(32'hC1C2C3C4);
    q.push_back(32'hD1D2D3D4); send_word(32'hD1D2D3D4);
    check("full_before_simul", 32'(full), 32'd1);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    send_byte(8'hE3, 1'b0);
    q.push_back(32'hE1E2E3E4);
    data_ready = 1'b1;
    send_byte(8'hE4, 1'b0);
    data_ready = 1'b0;
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_full", 32'(full), 32'd1);
    check("simul_head", data_out, 32'hB1B2B3B4);
    drain();

    // Asynchronous reset between edges discards everything.
    do_reset();
    send_byte(8'h77, 1'b1);
    q.push_back(32'h01010101); send_word(32'h01010101);
    q.push_back(32'h02020202); send_word(32'h02020202);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    check("pre_rst_valid", 32'(data_valid), 32'd1);
    check("pre_rst_errcnt", 32'(error_count), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    check("async_data_valid", 32'(data_valid), 32'd0);
    check("async_data_out", data_out, 32'h0);
    check("async_error_count", 32'(error_count), 32'd0);
    check("async_full", 32'(full), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(data_valid), 32'd0);
    q.push_back(32'hCAFEF00D); send_word(32'hCAFEF00D);
    drain();
    data_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    data_ready = 1'b0;
    check("single_word_only", 32'(data_valid), 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 254; i++) send_byte(8'(i), 1'b1);
    check("errcnt_254", 32'(error_count), 32'd254);
    send_byte(8'h00, 1'b1);
    check("errcnt_255", 32'(error_count), 32'd255);
    for (int i = 0; i < 45; i++) send_byte(8'(i), 1'b1);
    check("errcnt_saturated", 32'(error_count), 32'd255);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
